pie_encoder: RTL and testbench
==============================

# pie_encoder

Reader-side Pulse-Interval Encoding (PIE) transmitter for the EPC Class 1 Gen 2 forward link: the counterpart of the tag's PIE receiver. On `start` it drives `modout` through a delimiter, data-0, RTcal, optional TRcal, then `nbits` PIE data symbols, fetching each bit over a one-bit request handshake. It serves as the reader model in tag-level benches and as the forward-link modulator driver in reader builds.

## Interface
- `DELIM_CYCLES`, 25: delimiter low time in clk cycles.
- `TARI_CYCLES`, 16: data-0 symbol length, rising edge to rising edge.
- `DATA1_CYCLES`, 32: data-1 symbol length; RTcal length = `TARI_CYCLES + DATA1_CYCLES`.
- `TRCAL_CYCLES`, 64: TRcal symbol length.
- `PW_CYCLES`, 8: low-pulse width at the end of every symbol.
- All lengths must satisfy: `PW_CYCLES` < `TARI_CYCLES`, every length ≤ 1023, and `TRCAL_CYCLES` > RTcal. Valid values are the integrator's responsibility; the block does not check them.
- `clk` input 1: clock.
- `reset` input 1: reset, asynchronous, active-high.
- `start` input 1: one-cycle request to send a frame; sampled only in IDLE.
- `send_trcal` input 1: latched at start; 1 = preamble with TRcal, 0 = frame-sync without TRcal.
- `nbits` input 8: number of data bits, latched at start; 0 is legal.
- `bit_in` input 1: next data bit, sampled on the edge that ends a `bit_ready` cycle.
- `bit_ready` output 1: one-cycle pulse requesting `bit_in`.
- `modout` output 1: PIE line; idle high, low = carrier attenuated.
- `busy` output 1: frame in progress.
- `done` output 1: one-cycle pulse at frame end.

## Operation
- FSM states: IDLE, DELIM, SYM_HIGH, SYM_LOW.
- A symbol-type register holds DATA0, RTCAL, TRCAL or BIT.
- A 10-bit down-counter times each phase.
- Remaining bits are counted by an 8-bit register.
- Symbol shape: high for (len − `PW_CYCLES`) cycles, then low for `PW_CYCLES`. The symbol ends at the rising edge that starts the next phase, so rising-edge-to-rising-edge spacing equals the symbol length.
- IDLE: `modout`=1, `busy`=0. On `start`=1:
  - latch `send_trcal` and `nbits`;
  - go to DELIM; `modout`=0 for `DELIM_CYCLES`.
- DELIM → SYM_HIGH, type DATA0 (len `TARI_CYCLES`).
- DATA0 → RTCAL (len RTcal).
- RTCAL → TRCAL if `send_trcal`=1; otherwise go to BIT, or finish if remaining bits = 0.
- TRCAL → BIT, or finish if remaining bits = 0.
- BIT: len = `DATA1_CYCLES` if the latched bit is 1, else `TARI_CYCLES`. After each bit, decrement remaining bits; at 0, finish.
- Bit fetch: `bit_ready`=1 during the last SYM_LOW cycle of the symbol preceding each BIT symbol. `bit_in` is captured on that edge; upstream holds it valid during the `bit_ready` cycle. Exactly `nbits` pulses per frame.
- Finish: return to IDLE with `modout`=1 (the final rising edge), `busy`=0, and `done`=1 for that one cycle.
- `start` while `busy` is ignored. `start` on the same cycle as `done` is also ignored; the next frame needs `start` ≥1 cycle later.
- Inputs other than `bit_in` are ignored while busy.

## Timing
- Reset values: `modout`=1, `busy`=0, `done`=0, `bit_ready`=0, FSM IDLE, counters 0.
- Reset mid-frame immediately forces these values. No `done` is issued, and the partial frame is abandoned.
- All outputs are registered.
- Latency: `start` sampled at edge N gives `modout`=0 and `busy`=1 from cycle N+1.
- Frame length in cycles = `DELIM_CYCLES` + `TARI_CYCLES` + RTcal + (`send_trcal` ? `TRCAL_CYCLES` : 0) + Σ bit lengths. `done` and the final rising edge follow immediately.
- The phase counter loads (len − 1) at each phase entry and advances the phase at 0. There are no idle cycles between phases.

## Test plan
- Default parameters, `send_trcal`=1, `nbits`=2, bits 1,0:
  - `modout` low 25 cycles;
  - rising-edge spacings 16, 48, 64, 32, 16;
  - each low pulse 8 cycles;
  - total busy 201 cycles;
  - 2 `bit_ready` pulses;
  - one `done`.
- `send_trcal`=0, `nbits`=3, bits 0,1,1:
  - spacings 16, 48, 16, 32, 32;
  - no TRcal;
  - `done` after 169 cycles.
- `nbits`=0, `send_trcal`=1:
  - delimiter, data-0, RTcal, TRcal only;
  - zero `bit_ready` pulses;
  - `done` after 153 cycles.
- Repeated `start` during a frame and on the `done` cycle: ignored. A `start` 1 cycle later launches a new delimiter.
- Reset asserted mid-RTcal low phase: `modout`=1 immediately, `busy`=0, no `done`. The next `start` produces a complete correct frame.
- Loopback into the tag PIE receiver with `nbits`=8, pattern 0xA5:
  - receiver reports RTcal 48 and TRcal 64;
  - receiver recovers bits 1,0,1,0,0,1,0,1 in order.

Source files
------------

// File: rtl/pie_encoder.sv
// Reader-side PIE forward-link modulator: delimiter, data-0, RTcal, optional TRcal,
// then nbits data symbols, each bit fetched through a one-cycle bit_ready request.
module pie_encoder #(
    parameter int DELIM_CYCLES = 25,
    parameter int TARI_CYCLES  = 16,
    parameter int DATA1_CYCLES = 32,
    parameter int TRCAL_CYCLES = 64,
    parameter int PW_CYCLES    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       send_trcal,
    input  logic [7:0] nbits,
    input  logic       bit_in,
    output logic       bit_ready,
    output logic       modout,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, DELIM, SYM_HIGH, SYM_LOW} state_t;
    typedef enum logic [1:0] {DATA0, RTCAL, TRCAL, BIT} sym_t;

    localparam int RTCAL_CYCLES = TARI_CYCLES + DATA1_CYCLES;

    // Counter loads are (phase length - 1); high phases exclude the trailing low pulse.
    localparam logic [9:0] DELIM_LOAD = 10'(DELIM_CYCLES - 1);
    localparam logic [9:0] DATA0_HIGH = 10'(TARI_CYCLES - PW_CYCLES - 1);
    localparam logic [9:0] DATA1_HIGH = 10'(DATA1_CYCLES - PW_CYCLES - 1);
    localparam logic [9:0] RTCAL_HIGH = 10'(RTCAL_CYCLES - PW_CYCLES - 1);
    localparam logic [9:0] TRCAL_HIGH = 10'(TRCAL_CYCLES - PW_CYCLES - 1);
    localparam logic [9:0] LOW_LOAD   = 10'(PW_CYCLES - 1);

    state_t     state, state_n;
    sym_t       sym_type, type_n;
    logic [9:0] count, count_n;
    logic [7:0] remaining, remaining_n;
    logic       with_trcal, with_trcal_n;
    logic       ready_n, done_n, finish, next_is_bit;
    logic [9:0] bit_high;

    assign bit_high = bit_in ? DATA1_HIGH : DATA0_HIGH;

    // BIT symbols count the current bit in remaining, hence the > 1 test.
    assign next_is_bit = (sym_type == RTCAL && !with_trcal && remaining != 8'd0)
                      || (sym_type == TRCAL && remaining != 8'd0)
                      || (sym_type == BIT && remaining > 8'd1);

    always_comb begin
        state_n      = state;
        type_n       = sym_type;
        count_n      = count;
        remaining_n  = remaining;
        with_trcal_n = with_trcal;
        ready_n      = 1'b0;
        done_n       = 1'b0;
        finish       = 1'b0;
        case (state)
            IDLE: begin
                if (start && !done) begin
                    state_n      = DELIM;
                    count_n      = DELIM_LOAD;
                    with_trcal_n = send_trcal;
                    remaining_n  = nbits;
                end
            end
            DELIM: begin
                if (count == 10'd0) begin
                    state_n = SYM_HIGH;
                    type_n  = DATA0;
                    count_n = DATA0_HIGH;
                end else begin
                    count_n = count - 10'd1;
                end
            end
            SYM_HIGH: begin
                if (count == 10'd0) begin
                    state_n = SYM_LOW;
                    count_n = LOW_LOAD;
                    ready_n = next_is_bit && (PW_CYCLES == 1);
                end else begin
                    count_n = count - 10'd1;
                end
            end
            SYM_LOW: begin
                if (count != 10'd0) begin
                    count_n = count - 10'd1;
                    ready_n = next_is_bit && (count == 10'd1);
                end else begin
                    state_n = SYM_HIGH;
                    case (sym_type)
                        DATA0: begin
                            type_n  = RTCAL;
                            count_n = RTCAL_HIGH;
                        end
                        RTCAL: begin
                            if (with_trcal) begin
                                type_n  = TRCAL;
                                count_n = TRCAL_HIGH;
                            end else if (remaining != 8'd0) begin
                                type_n  = BIT;
                                count_n = bit_high;
                            end else begin
                                finish = 1'b1;
                            end
                        end
                        TRCAL: begin
                            if (remaining != 8'd0) begin
                                type_n  = BIT;
                                count_n = bit_high;
                            end else begin
                                finish = 1'b1;
                            end
                        end
                        BIT: begin
                            remaining_n = remaining - 8'd1;
                            if (remaining > 8'd1) begin
                                count_n = bit_high;
                            end else begin
                                finish = 1'b1;
                            end
                        end
                    endcase
                end
            end
        endcase
        if (finish) begin
            state_n = IDLE;
            count_n = 10'd0;
            done_n  = 1'b1;
        end
    end

    // Outputs are registered from the next-state decode so they change with the phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            sym_type   <= DATA0;
            count      <= 10'd0;
            remaining  <= 8'd0;
            with_trcal <= 1'b0;
            modout     <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            bit_ready  <= 1'b0;
        end else begin
            state      <= state_n;
            sym_type   <= type_n;
            count      <= count_n;
            remaining  <= remaining_n;
            with_trcal <= with_trcal_n;
            modout     <= !(state_n == DELIM || state_n == SYM_LOW);
            busy       <= (state_n != IDLE);
            done       <= done_n;
            bit_ready  <= ready_n;
        end
    end

endmodule

// File: tb/tb_pie_encoder.sv
// Directed bench for pie_encoder: frame vectors with hand-computed edge spacings,
// plus start-ignore and mid-frame reset sequences and a small PIE receiver model.
module tb_pie_encoder;

    logic       clk = 1'b0;
    logic       reset, start, send_trcal, bit_in;
    logic [7:0] nbits;
    logic       bit_ready, modout, busy, done;

    always #5 clk = ~clk;

    pie_encoder dut (
        .clk(clk), .reset(reset), .start(start), .send_trcal(send_trcal),
        .nbits(nbits), .bit_in(bit_in), .bit_ready(bit_ready),
        .modout(modout), .busy(busy), .done(done)
    );

    typedef struct packed {
        logic       trcal;
        logic [7:0] n;
        logic [7:0] bits;
        int         exp_busy;
        int         exp_nsp;
    } frame_t;

    frame_t vec [0:4];
    int exp_sp [0:4][0:11];

    int tests = 0;
    int fails = 0;

    int rise_t [0:15];
    int low_w  [0:15];
    int nr, busy_cnt, ready_cnt, done_cnt, bit_idx;
    logic timed_out;
    logic [7:0] serve_bits;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic trcal, input logic [7:0] n, input logic [7:0] bits);
        @(negedge clk);
        start      = 1'b1;
        send_trcal = trcal;
        nbits      = n;
        serve_bits = bits;
        @(negedge clk);
        start      = 1'b0;
        send_trcal = !trcal;
        nbits      = ~n;
    endtask

    // Called on the first busy cycle; records rising edges, low widths and pulses until done.
    task automatic monitor_frame(input int budget);
        logic prev;
        int   fall_t;
        nr = 0; busy_cnt = 0; ready_cnt = 0; done_cnt = 0; bit_idx = 0;
        timed_out = 1'b1;
        prev = 1'b1;
        fall_t = 0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (busy) busy_cnt++;
            if (bit_ready) begin
                ready_cnt++;
                bit_in = serve_bits[bit_idx[2:0]];
                bit_idx++;
            end
            if (prev && !modout) fall_t = cyc;
            if (!prev && modout && nr < 16) begin
                rise_t[nr] = cyc;
                low_w[nr]  = cyc - fall_t;
                nr++;
            end
            prev = modout;
            if (done) begin
                done_cnt++;
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_frame(input int i);
        int sp [0:15];
        int first;
        check_output($sformatf("f%0d_timeout", i), timed_out, 0);
        check_output($sformatf("f%0d_busy_cycles", i), busy_cnt, vec[i].exp_busy);
        check_output($sformatf("f%0d_ready_pulses", i), ready_cnt, vec[i].n);
        check_output($sformatf("f%0d_done_pulses", i), done_cnt, 1);
        check_output($sformatf("f%0d_delim_low", i), low_w[0], 25);
        check_output($sformatf("f%0d_rise_count", i), nr, vec[i].exp_nsp + 1);
        if (nr == vec[i].exp_nsp + 1) begin
            for (int k = 0; k < vec[i].exp_nsp; k++) begin
                sp[k] = rise_t[k+1] - rise_t[k];
                check_output($sformatf("f%0d_spacing%0d", i, k), sp[k], exp_sp[i][k]);
                check_output($sformatf("f%0d_low%0d", i, k), low_w[k+1], 8);
            end
            // Receiver model: a data symbol longer than RTcal/2 decodes as 1.
            first = vec[i].trcal ? 3 : 2;
            for (int j = 0; j < int'(vec[i].n); j++)
                check_output($sformatf("f%0d_rx_bit%0d", i, j),
                             (sp[first + j] > sp[1] / 2) ? 1 : 0, vec[i].bits[j]);
        end
        @(negedge clk);
        check_output($sformatf("f%0d_post_done", i), done, 0);
        check_output($sformatf("f%0d_post_modout", i), modout, 1);
        check_output($sformatf("f%0d_post_busy", i), busy, 0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got running, expected finished");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        int rst_done;
        vec[0] = '{trcal: 1'b1, n: 8'd2, bits: 8'b0000_0001, exp_busy: 201, exp_nsp: 5};
        vec[1] = '{trcal: 1'b0, n: 8'd3, bits: 8'b0000_0110, exp_busy: 169, exp_nsp: 5};
        vec[2] = '{trcal: 1'b1, n: 8'd0, bits: 8'b0000_0000, exp_busy: 153, exp_nsp: 3};
        vec[3] = '{trcal: 1'b1, n: 8'd8, bits: 8'hA5,        exp_busy: 345, exp_nsp: 11};
        vec[4] = '{trcal: 1'b0, n: 8'd1, bits: 8'b0000_0001, exp_busy: 121, exp_nsp: 3};
        exp_sp = '{'{16, 48, 64, 32, 16,  0,  0,  0,  0,  0,  0, 0},
                   '{16, 48, 16, 32, 32,  0,  0,  0,  0,  0,  0, 0},
                   '{16, 48, 64,  0,  0,  0,  0,  0,  0,  0,  0, 0},
                   '{16, 48, 64, 32, 16, 32, 16, 16, 32, 16, 32, 0},
                   '{16, 48, 32,  0,  0,  0,  0,  0,  0,  0,  0, 0}};

        reset = 1'b1; start = 1'b0; send_trcal = 1'b0; nbits = 8'd0; bit_in = 1'b0;
        serve_bits = 8'd0;
        repeat (3) @(negedge clk);
        check_output("reset_modout", modout, 1);
        check_output("reset_busy", busy, 0);
        check_output("reset_done", done, 0);
        check_output("reset_bit_ready", bit_ready, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            apply_stimulus(vec[i].trcal, vec[i].n, vec[i].bits);
            check_output($sformatf("f%0d_start_latency", i), {busy, modout}, 2'b10);
            monitor_frame(2000);
            check_frame(i);
        end

        // start held high through a whole frame and its done cycle.
        @(negedge clk);
        start = 1'b1; send_trcal = 1'b0; nbits = 8'd0;
        @(negedge clk);
        monitor_frame(500);
        check_output("hold_busy_cycles", busy_cnt, 89);
        check_output("hold_done_pulses", done_cnt, 1);
        @(negedge clk);
        check_output("hold_done_cycle_start_ignored", busy, 0);
        check_output("hold_idle_modout", modout, 1);
        @(negedge clk);
        start = 1'b0;
        check_output("hold_relaunch", {busy, modout}, 2'b10);
        monitor_frame(500);
        check_output("relaunch_busy_cycles", busy_cnt, 89);
        check_output("relaunch_delim_low", low_w[0], 25);
        check_output("relaunch_done_pulses", done_cnt, 1);
        @(negedge clk);

        // Reset during the RTcal low phase (frame cycles 81..88).
        apply_stimulus(1'b1, 8'd2, 8'b0000_0001);
        repeat (83) @(negedge clk);
        check_output("mid_rtcal_low", modout, 0);
        #1 reset = 1'b1;
        #1;
        check_output("mid_reset_modout", modout, 1);
        check_output("mid_reset_busy", busy, 0);
        check_output("mid_reset_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        rst_done = 0;
        repeat (5) begin
            @(negedge clk);
            if (done || busy) rst_done++;
        end
        check_output("post_reset_quiet", rst_done, 0);

        apply_stimulus(vec[0].trcal, vec[0].n, vec[0].bits);
        monitor_frame(2000);
        check_frame(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
